// File: rtl/lsu_mem_access_if.sv
// Signal bundle between the memory stage, the load/store unit and the data-memory bus.
// The LSU takes the slave view; the pipeline/memory environment takes the master view.
interface lsu_mem_access_if #(
  parameter int XLEN = 32
);
  localparam int BYTES = XLEN / 8;

  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [2:0]       req_funct3_i;
  logic [XLEN-1:0]  req_addr_i;
  logic [XLEN-1:0]  req_wdata_i;
  logic             mem_req_o;
  logic             mem_gnt_i;
  logic             mem_we_o;
  logic [XLEN-1:0]  mem_addr_o;
  logic [BYTES-1:0] mem_be_o;
  logic [XLEN-1:0]  mem_wdata_o;
  logic             mem_rvalid_i;
  logic [XLEN-1:0]  mem_rdata_i;
  logic             resp_valid_o;
  logic [XLEN-1:0]  resp_rdata_o;
  logic             resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store access unit: one access per handshake, one or two bus beats (two when the
// access straddles a bus word), lane-positioned store data and extended load results.
module lsu_mem_access #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  lsu_mem_access_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OW    = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, ERR} state_t;
  state_t state;

  logic [3:0]         dec_size;
  logic               dec_unsigned;
  logic               dec_illegal;
  logic               dec_misaligned;
  logic               dec_cross;
  logic [OW-1:0]      dec_off;
  logic [XLEN-1:0]    dec_base;
  logic [2*BYTES-1:0] dec_be;
  logic [2*XLEN-1:0]  dec_wdata;

  logic               we_q;
  logic               unsigned_q;
  logic               cross_q;
  logic [3:0]         size_q;
  logic [OW-1:0]      off_q;
  logic [BYTES-1:0]   be1_q;
  logic [XLEN-1:0]    wdata1_q;
  logic [XLEN-1:0]    beat0_q;
  logic [2*XLEN-1:0]  merge_wide;
  logic [XLEN-1:0]    load_result;

  // Keeps the low size bytes and fills the rest with the sign bit or zeros.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] data,
                                             input logic [3:0]      size,
                                             input logic            zero_ext);
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top;
    logic            sign;
    keep = ~({XLEN{1'b1}} << {size, 3'b000});
    top  = keep & ~(keep >> 1);
    sign = ~zero_ext & (|(data & top));
    return (data & keep) | ({XLEN{sign}} & ~keep);
  endfunction

  // Decode the incoming request: size, extension, legality and how it maps onto bus lanes.
  always_comb begin
    dec_size     = 4'd1;
    dec_unsigned = 1'b0;
    dec_illegal  = 1'b0;
    case (bus.req_funct3_i)
      3'b000: dec_size = 4'd1;
      3'b001: dec_size = 4'd2;
      3'b010: dec_size = 4'd4;
      3'b011: begin
        dec_size    = 4'd8;
        dec_illegal = (XLEN == 32);
      end
      3'b100: begin
        dec_size     = 4'd1;
        dec_unsigned = 1'b1;
        dec_illegal  = bus.req_we_i;
      end
      3'b101: begin
        dec_size     = 4'd2;
        dec_unsigned = 1'b1;
        dec_illegal  = bus.req_we_i;
      end
      3'b110: begin
        dec_size     = 4'd4;
        dec_unsigned = 1'b1;
        dec_illegal  = bus.req_we_i | (XLEN == 32);
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_off        = bus.req_addr_i[OW-1:0];
    dec_base       = {bus.req_addr_i[XLEN-1:OW], {OW{1'b0}}};
    dec_misaligned = |(bus.req_addr_i[3:0] & (dec_size - 4'd1));
    dec_cross      = (int'(dec_off) + int'(dec_size)) > BYTES;
    // Low half of the wide vectors is beat 0, the overflow into the high half is beat 1.
    dec_be    = {{BYTES{1'b0}}, ~({BYTES{1'b1}} << dec_size)} << dec_off;
    dec_wdata = {{XLEN{1'b0}}, bus.req_wdata_i & ~({XLEN{1'b1}} << {dec_size, 3'b000})}
                << {dec_off, 3'b000};
  end

  // Align returned read data so the accessed bytes start at bit 0, then extend them.
  always_comb begin
    merge_wide  = {bus.mem_rdata_i, (state == WAIT1) ? beat0_q : bus.mem_rdata_i}
                  >> {off_q, 3'b000};
    load_result = we_q ? '0 : extend(merge_wide[XLEN-1:0], size_q, unsigned_q);
  end

  // Access sequencer with registered handshake, bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      we_q             <= 1'b0;
      unsigned_q       <= 1'b0;
      cross_q          <= 1'b0;
      size_q           <= 4'd1;
      off_q            <= '0;
      be1_q            <= '0;
      wdata1_q         <= '0;
      beat0_q          <= '0;
      bus.req_ready_o  <= 1'b1;
      bus.mem_req_o    <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_be_o     <= '0;
      bus.mem_wdata_o  <= '0;
      bus.resp_valid_o <= 1'b0;
      bus.resp_rdata_o <= '0;
      bus.resp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.req_ready_o <= 1'b0;
            we_q            <= bus.req_we_i;
            unsigned_q      <= dec_unsigned;
            cross_q         <= dec_cross;
            size_q          <= dec_size;
            off_q           <= dec_off;
            be1_q           <= dec_be[2*BYTES-1:BYTES];
            wdata1_q        <= dec_wdata[2*XLEN-1:XLEN];
            if (dec_illegal || (!MISALIGN_EN && dec_misaligned)) begin
              state            <= ERR;
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b1;
            end else begin
              state           <= REQ0;
              bus.mem_req_o   <= 1'b1;
              bus.mem_we_o    <= bus.req_we_i;
              bus.mem_addr_o  <= dec_base;
              bus.mem_be_o    <= dec_be[BYTES-1:0];
              bus.mem_wdata_o <= dec_wdata[XLEN-1:0];
            end
          end
        end
        REQ0: begin
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            state         <= WAIT0;
          end
        end
        WAIT0: begin
          if (bus.mem_rvalid_i) begin
            beat0_q <= bus.mem_rdata_i;
            if (cross_q) begin
              state           <= REQ1;
              bus.mem_req_o   <= 1'b1;
              bus.mem_addr_o  <= bus.mem_addr_o + XLEN'(BYTES);
              bus.mem_be_o    <= be1_q;
              bus.mem_wdata_o <= wdata1_q;
            end else begin
              state            <= RESP;
              bus.resp_valid_o <= 1'b1;
              bus.resp_rdata_o <= load_result;
            end
          end
        end
        REQ1: begin
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            state         <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid_i) begin
            state            <= RESP;
            bus.resp_valid_o <= 1'b1;
            bus.resp_rdata_o <= load_result;
          end
        end
        RESP, ERR: begin
          state            <= IDLE;
          bus.resp_valid_o <= 1'b0;
          bus.resp_err_o   <= 1'b0;
          bus.resp_rdata_o <= '0;
          bus.req_ready_o  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: two XLEN=32 instances (split-capable and strict-alignment)
// share one stimulus path; a byte-addressed memory model supplies read data and predicts
// bus beats, latency and the extended load result for each access.
module tb_lsu_mem_access;
  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic req_valid, req_we, gnt, rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rdata;

  lsu_mem_access_if #(.XLEN(32)) bus_a ();
  lsu_mem_access_if #(.XLEN(32)) bus_b ();

  assign bus_a.req_valid_i  = req_valid & ~sel;
  assign bus_a.req_we_i     = req_we;
  assign bus_a.req_funct3_i = req_funct3;
  assign bus_a.req_addr_i   = req_addr;
  assign bus_a.req_wdata_i  = req_wdata;
  assign bus_a.mem_gnt_i    = gnt & ~sel;
  assign bus_a.mem_rvalid_i = rvalid & ~sel;
  assign bus_a.mem_rdata_i  = rdata;
  assign bus_b.req_valid_i  = req_valid & sel;
  assign bus_b.req_we_i     = req_we;
  assign bus_b.req_funct3_i = req_funct3;
  assign bus_b.req_addr_i   = req_addr;
  assign bus_b.req_wdata_i  = req_wdata;
  assign bus_b.mem_gnt_i    = gnt & sel;
  assign bus_b.mem_rvalid_i = rvalid & sel;
  assign bus_b.mem_rdata_i  = rdata;

  lsu_mem_access #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  lsu_mem_access #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  logic        o_ready, o_req, o_we, o_rvalid, o_err;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;

  // Observe whichever instance the current access targets.
  always_comb begin
    if (sel) begin
      o_ready = bus_b.req_ready_o;  o_req = bus_b.mem_req_o;      o_we = bus_b.mem_we_o;
      o_addr  = bus_b.mem_addr_o;   o_be  = bus_b.mem_be_o;       o_wdata = bus_b.mem_wdata_o;
      o_rvalid = bus_b.resp_valid_o; o_rdata = bus_b.resp_rdata_o; o_err = bus_b.resp_err_o;
    end else begin
      o_ready = bus_a.req_ready_o;  o_req = bus_a.mem_req_o;      o_we = bus_a.mem_we_o;
      o_addr  = bus_a.mem_addr_o;   o_be  = bus_a.mem_be_o;       o_wdata = bus_a.mem_wdata_o;
      o_rvalid = bus_a.resp_valid_o; o_rdata = bus_a.resp_rdata_o; o_err = bus_a.resp_err_o;
    end
  end

  logic [7:0]  mem_b [0:511];
  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] obs_addr  [0:1];
  logic [3:0]  obs_be    [0:1];
  logic        obs_we    [0:1];
  logic [31:0] obs_wdata [0:1];
  int          nb;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] wordAt(input logic [31:0] a);
    logic [8:0] i;
    i = {a[8:2], 2'b00};
    return {mem_b[i + 9'd3], mem_b[i + 9'd2], mem_b[i + 9'd1], mem_b[i]};
  endfunction

  task automatic setWord(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem_b[9'(a + 32'(i))] = v[8*i +: 8];
  endtask

  // Predict the access from byte-level rules and compare with what was observed.
  task automatic checkModel(input bit s, input bit we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int d0, input int d1);
    int n, lat, ebeats;
    bit legal, err, split;
    logic [31:0] expv, base, wbase, a, shifted, ewd, lmask;
    logic [3:0] ebe;
    n = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err = !legal || (s && (addr % n) != 0);
    base = addr & ~32'd3;
    split = !err && ((addr + n) > (base + 32'd4));
    expv = 32'd0;
    if (err) begin
      ebeats = 0;
      lat = 1;
    end else begin
      ebeats = split ? 2 : 1;
      lat = 3 + d0 + (split ? 2 + d1 : 0);
      if (!we) begin
        for (int i = 0; i < n; i++) expv |= 32'(mem_b[9'(addr + 32'(i))]) << (8 * i);
        if (f3 < 3'd4 && expv[8*n-1]) expv |= ~((32'd1 << (8 * n)) - 32'd1);
      end
    end
    checkOutput("resp_err", 32'(last_err), 32'(err));
    checkOutput("latency", last_lat, lat);
    checkOutput("resp_rdata", last_rdata, expv);
    checkOutput("beat_count", nb, ebeats);
    for (int k = 0; k < ebeats; k++) begin
      wbase = base + 32'(4 * k);
      ebe = 4'b0;
      ewd = 32'd0;
      lmask = 32'd0;
      for (int l = 0; l < 4; l++) begin
        a = wbase + 32'(l);
        if (a >= addr && a < addr + n) begin
          ebe[l] = 1'b1;
          shifted = wd >> (8 * (a - addr));
          ewd[8*l +: 8] = shifted[7:0];
          lmask[8*l +: 8] = 8'hFF;
        end
      end
      checkOutput("beat_addr", obs_addr[1'(k)], wbase);
      checkOutput("beat_be", 32'(obs_be[1'(k)]), 32'(ebe));
      checkOutput("beat_we", 32'(obs_we[1'(k)]), 32'(we));
      if (we) checkOutput("beat_wdata", obs_wdata[1'(k)] & lmask, ewd);
    end
    if (we && !err)
      for (int i = 0; i < n; i++) mem_b[9'(addr + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  // Issue one access, act as the bus slave with the given grant delays, collect the result.
  task automatic applyStimulus(input bit s, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int d0, input int d1, input bit abort);
    int cyc, wcnt;
    bit inbeat, pend, done;
    logic [31:0] pend_addr;
    @(negedge clk);
    sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    #1 checkOutput("ready_idle", 32'(o_ready), 32'd1);
    nb = 0; cyc = 0; wcnt = 0; inbeat = 0; pend = 0; done = 0; pend_addr = 32'd0;
    @(posedge clk);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      if (o_rvalid) begin
        done = 1; last_lat = cyc; last_rdata = o_rdata; last_err = o_err;
      end else if (pend) begin
        checkOutput("req_drop", 32'(o_req), 32'd0);
        rvalid = 1'b1; rdata = wordAt(pend_addr); pend = 0;
      end else if (o_req) begin
        if (!inbeat) begin
          inbeat = 1;
          if (nb < 2) begin
            obs_addr[1'(nb)] = o_addr; obs_be[1'(nb)] = o_be;
            obs_we[1'(nb)] = o_we; obs_wdata[1'(nb)] = o_wdata;
            wcnt = (nb == 0) ? d0 : d1;
          end
          nb++;
          if (abort && nb == 2) begin
            #2 rst = 1'b1;
            #1 checkOutput("rst_req", 32'(o_req), 32'd0);
            checkOutput("rst_resp", 32'(o_rvalid), 32'd0);
            checkOutput("rst_ready", 32'(o_ready), 32'd1);
            @(negedge clk);
            rst = 1'b0;
            repeat (2) begin
              @(negedge clk);
              checkOutput("post_rst_ready", 32'(o_ready), 32'd1);
              checkOutput("post_rst_resp", 32'(o_rvalid), 32'd0);
            end
            return;
          end
        end else if (nb <= 2) begin
          checkOutput("hold_addr", o_addr, obs_addr[1'(nb - 1)]);
          checkOutput("hold_be", 32'(o_be), 32'(obs_be[1'(nb - 1)]));
          checkOutput("hold_wdata", o_wdata, obs_wdata[1'(nb - 1)]);
        end
        if (wcnt == 0) begin
          gnt = 1'b1; inbeat = 0; pend = 1; pend_addr = o_addr;
        end else begin
          wcnt--;
        end
      end
    end
    checkOutput("resp_seen", 32'(done), 32'd1);
    if (!done) return;
    @(negedge clk);
    checkOutput("resp_pulse", 32'(o_rvalid), 32'd0);
    checkOutput("ready_back", 32'(o_ready), 32'd1);
    checkModel(s, we, f3, addr, wd, d0, d1);
  endtask

  // Reset check, the directed scenarios, then randomized accesses on both instances.
  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    for (int i = 0; i < 512; i++) mem_b[9'(i)] = 8'($urandom);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checkOutput("rst_ready_init", 32'(o_ready), 32'd1);
      checkOutput("rst_mem_req", 32'(o_req), 32'd0);
      checkOutput("rst_resp_valid", 32'(o_rvalid), 32'd0);
      checkOutput("rst_resp_err", 32'(o_err), 32'd0);
      checkOutput("rst_resp_rdata", o_rdata, 32'd0);
      checkOutput("rst_mem_be", 32'(o_be), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    setWord(32'h100, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 1'b0);
    checkOutput("tp_lw_rdata", last_rdata, 32'hDEADBEEF);
    checkOutput("tp_lw_be", 32'(obs_be[0]), 32'hF);
    checkOutput("tp_lw_latency", last_lat, 3);

    setWord(32'h100, 32'h80123456);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 1'b0);
    checkOutput("tp_lb_rdata", last_rdata, 32'hFFFFFF80);
    checkOutput("tp_lb_be", 32'(obs_be[0]), 32'h8);
    applyStimulus(1'b0, 1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 1'b0);
    checkOutput("tp_lbu_rdata", last_rdata, 32'h00000080);

    setWord(32'h100, 32'h55667788);
    setWord(32'h104, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h102, 32'd0, 0, 0, 1'b0);
    checkOutput("tp_split_rdata", last_rdata, 32'h33445566);
    checkOutput("tp_split_be0", 32'(obs_be[0]), 32'hC);
    checkOutput("tp_split_be1", 32'(obs_be[1]), 32'h3);
    checkOutput("tp_split_addr1", obs_addr[1], 32'h104);

    applyStimulus(1'b0, 1'b1, 3'b001, 32'h103, 32'h0000ABCD, 0, 0, 1'b0);
    checkOutput("tp_sh_wdata0", obs_wdata[0] & 32'hFF000000, 32'hCD000000);
    checkOutput("tp_sh_wdata1", obs_wdata[1] & 32'h000000FF, 32'h000000AB);
    checkOutput("tp_sh_rdata", last_rdata, 32'd0);

    applyStimulus(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 0, 0, 1'b0);
    checkOutput("tp_strict_err", 32'(last_err), 32'd1);
    checkOutput("tp_strict_beats", nb, 0);
    applyStimulus(1'b0, 1'b0, 3'b011, 32'h100, 32'd0, 0, 0, 1'b0);
    checkOutput("tp_ld32_err", 32'(last_err), 32'd1);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h104, 32'h12345678, 3, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h102, 32'd0, 0, 2, 1'b1);

    for (int t = 0; t < 200; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 32'($urandom_range(32'h100, 32'h1F0)),
                    $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  // Last-resort bound on total run time.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors so far", vecCount);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
